iic_phase_gen: RTL

IIC_PHASE_GEN -- requirements
Module: iic_phase_gen

---
 rtl/iic_phase_gen.sv | 88 ++++++++
 1 files changed

// File: rtl/iic_phase_gen.sv
// Phase-tick generator for an IIC-style bus engine: splits each bus bit period
// into 2**PH_W equal phases of (div_q+1) clk_sys cycles, with clock-stretch freeze.
module iic_phase_gen #(
  parameter int U_DLY = 1,
  parameter int DW    = 16,
  parameter int PH_W  = 2
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            hold,
  input  logic [DW-1:0]   div_cfg,
  output logic            ph_tick,
  output logic [PH_W-1:0] ph_idx,
  output logic            period_end,
  output logic            busy
);

  localparam logic [DW-1:0]   CNT_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0]   CNT_ONE  = DW'(1);
  localparam logic [PH_W-1:0] PH_ZERO  = {PH_W{1'b0}};
  localparam logic [PH_W-1:0] PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0] PH_LAST  = {PH_W{1'b1}};

  logic [DW-1:0]   cnt_r, cnt_s;
  logic [DW-1:0]   div_q_r, div_q_s;
  logic [PH_W-1:0] phase_r, phase_s;
  logic [PH_W-1:0] ph_idx_r, ph_idx_s;
  logic            ph_tick_r, ph_tick_s;
  logic            period_end_r, period_end_s;
  logic            busy_r;

  // Next-state decode: idle clears, hold freezes, otherwise count or close a phase.
  always_comb begin
    cnt_s        = cnt_r;
    div_q_s      = div_q_r;
    phase_s      = phase_r;
    ph_idx_s     = ph_idx_r;
    ph_tick_s    = 1'b0;
    period_end_s = 1'b0;
    if (!enable) begin
      cnt_s    = CNT_ZERO;
      phase_s  = PH_ZERO;
      div_q_s  = div_cfg;
      ph_idx_s = PH_ZERO;
    end else if (hold) begin
      ph_tick_s    = 1'b0;
      period_end_s = 1'b0;
    end else if (cnt_r >= div_q_r) begin
      // >= rather than == so a stale or corrupted cnt always falls back to a boundary
      cnt_s        = CNT_ZERO;
      ph_tick_s    = 1'b1;
      ph_idx_s     = phase_r;
      phase_s      = phase_r + PH_ONE;
      period_end_s = (phase_r == PH_LAST);
      div_q_s      = div_cfg;
    end else begin
      cnt_s = cnt_r + CNT_ONE;
    end
  end

  // State and output registers; the divider is only re-sampled at phase edges or idle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= CNT_ZERO;
      div_q_r      <= CNT_ZERO;
      phase_r      <= PH_ZERO;
      ph_idx_r     <= PH_ZERO;
      ph_tick_r    <= 1'b0;
      period_end_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      div_q_r      <= div_q_s;
      phase_r      <= phase_s;
      ph_idx_r     <= ph_idx_s;
      ph_tick_r    <= ph_tick_s;
      period_end_r <= period_end_s;
      busy_r       <= enable;
    end
  end

  assign ph_tick    = ph_tick_r;
  assign ph_idx     = ph_idx_r;
  assign period_end = period_end_r;
  assign busy       = busy_r;

endmodule
